alu: RTL and testbench

//  Integer ALU of the processor execute stage. Computes one of 16 operations on two

---
 rtl/alu_if.sv | 21 ++
 rtl/alu.sv | 78 +++++++
 tb/tb_alu.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Operand/control bundle between the execute-stage control and the ALU.
// The ALU takes the slave side; whatever drives operands takes the master side.
interface alu_if #(
   parameter int NBITS = 32
);
   logic [3:0]       ALU_control;
   logic [NBITS-1:0] operando_A;
   logic [NBITS-1:0] operando_B;
   logic [NBITS-1:0] result_op;
   logic             zero;

   modport master (
      output ALU_control, operando_A, operando_B,
      input  result_op, zero
   );

   modport slave (
      input  ALU_control, operando_A, operando_B,
      output result_op, zero
   );
endinterface

// File: rtl/alu.sv
// Execute-stage integer ALU: 16 operations, result and zero flag registered
// with one cycle of latency. Reset clears the result and raises zero.
module alu #(
   parameter int NBITS = 32
) (
   input  logic clk,
   input  logic rst_n,
   alu_if.slave bus
);
   localparam int SHW = $clog2(NBITS);

   typedef enum logic [3:0] {
      OP_ADD   = 4'h0,
      OP_SUB   = 4'h1,
      OP_AND   = 4'h2,
      OP_OR    = 4'h3,
      OP_XOR   = 4'h4,
      OP_NOR   = 4'h5,
      OP_SLT   = 4'h6,
      OP_SLTU  = 4'h7,
      OP_SLL   = 4'h8,
      OP_SRL   = 4'h9,
      OP_SRA   = 4'hA,
      OP_LUI   = 4'hB,
      OP_PASSA = 4'hC,
      OP_PASSB = 4'hD,
      OP_SEQ   = 4'hE,
      OP_RSV   = 4'hF
   } op_e;

   op_e              op;
   logic [NBITS-1:0] a;
   logic [NBITS-1:0] b;
   logic [NBITS-1:0] f;
   logic [SHW-1:0]   sh;

   assign op = op_e'(bus.ALU_control);
   assign a  = bus.operando_A;
   assign b  = bus.operando_B;
   // Only the low bits of A count, so shift amounts >= NBITS wrap around.
   assign sh = a[SHW-1:0];

   always_comb begin
      // NOTE: f gets a default before the case so no code path leaves it
      // unassigned; otherwise synthesis would infer a latch.
      f = '0;
      case (op)
         OP_ADD:   f = a + b;
         OP_SUB:   f = a - b;
         OP_AND:   f = a & b;
         OP_OR:    f = a | b;
         OP_XOR:   f = a ^ b;
         OP_NOR:   f = ~(a | b);
         OP_SLT:   f = {{(NBITS-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU:  f = {{(NBITS-1){1'b0}}, (a < b)};
         OP_SLL:   f = b << sh;
         OP_SRL:   f = b >> sh;
         OP_SRA:   f = $signed(b) >>> sh;
         OP_LUI:   f = b << 16;
         OP_PASSA: f = a;
         OP_PASSB: f = b;
         OP_SEQ:   f = {{(NBITS-1){1'b0}}, (a == b)};
         default:  f = '0;
      endcase
   end

   // NOTE: registered state uses non-blocking assignments so every flop
   // samples pre-edge values, matching the hardware.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.result_op <= '0;
         bus.zero      <= 1'b1;
      end else begin
         bus.result_op <= f;
         bus.zero      <= (f == '0);
      end
   end
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: table of directed vectors applied back-to-back,
// plus hand-written sequences for input isolation and asynchronous reset.
module tb_alu;
   localparam int NBITS = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   alu_if #(.NBITS(NBITS)) bus ();

   alu #(.NBITS(NBITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  ctl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_r;
      logic        exp_z;
   } vec_t;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   vec_t vecs[$];

   initial begin
      // Directed vectors with hand-computed results.
      vecs.push_back('{4'h0, 32'd1, 32'd2, 32'h0000_0003, 1'b0});
      vecs.push_back('{4'h1, 32'd1, 32'd2, 32'hFFFF_FFFF, 1'b0});
      vecs.push_back('{4'h2, 32'd1, 32'd2, 32'h0000_0000, 1'b1});
      vecs.push_back('{4'h3, 32'd1, 32'd2, 32'h0000_0003, 1'b0});
      vecs.push_back('{4'h4, 32'd1, 32'd2, 32'h0000_0003, 1'b0});
      vecs.push_back('{4'h5, 32'd1, 32'd2, 32'hFFFF_FFFC, 1'b0});
      vecs.push_back('{4'h6, 32'd1, 32'd2, 32'h0000_0001, 1'b0});
      vecs.push_back('{4'h7, 32'd1, 32'd2, 32'h0000_0001, 1'b0});
      vecs.push_back('{4'h8, 32'd1, 32'd2, 32'h0000_0004, 1'b0});
      vecs.push_back('{4'h9, 32'd1, 32'd2, 32'h0000_0001, 1'b0});
      vecs.push_back('{4'hB, 32'd1, 32'd2, 32'h0002_0000, 1'b0});
      vecs.push_back('{4'hC, 32'd1, 32'd2, 32'h0000_0001, 1'b0});
      vecs.push_back('{4'hD, 32'd1, 32'd2, 32'h0000_0002, 1'b0});
      vecs.push_back('{4'hE, 32'd1, 32'd2, 32'h0000_0000, 1'b1});
      vecs.push_back('{4'hF, 32'd1, 32'd2, 32'h0000_0000, 1'b1});
      vecs.push_back('{4'h6, 32'hFFFF_FFFF, 32'd1, 32'h0000_0001, 1'b0});
      vecs.push_back('{4'h7, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1});
      vecs.push_back('{4'h0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1});
      vecs.push_back('{4'hA, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b0});
      vecs.push_back('{4'h9, 32'd4, 32'h8000_0000, 32'h0800_0000, 1'b0});
      vecs.push_back('{4'hA, 32'd36, 32'h7000_0000, 32'h0700_0000, 1'b0});
      vecs.push_back('{4'h8, 32'd33, 32'd1, 32'h0000_0002, 1'b0});
      vecs.push_back('{4'h8, 32'd31, 32'd1, 32'h8000_0000, 1'b0});
      vecs.push_back('{4'hE, 32'h1234, 32'h1234, 32'h0000_0001, 1'b0});
      vecs.push_back('{4'h1, 32'h1234, 32'h1234, 32'h0000_0000, 1'b1});
      vecs.push_back('{4'hB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_0000, 1'b0});
      vecs.push_back('{4'hC, 32'd0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
      vecs.push_back('{4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});

      // Reset asserted before any clock edge, with arbitrary inputs applied.
      bus.ALU_control = 4'($urandom);
      bus.operando_A  = $urandom;
      bus.operando_B  = $urandom;
      #1 rst_n = 1'b0;
      #1;
      check("reset_result", bus.result_op, 32'h0);
      check("reset_zero", {31'b0, bus.zero}, 32'h1);

      // Vectors change every cycle; each result is checked one edge later.
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         bus.ALU_control = vecs[i].ctl;
         bus.operando_A  = vecs[i].a;
         bus.operando_B  = vecs[i].b;
         @(posedge clk);
         #1;
         check($sformatf("v%0d_ctl%0h_result", i, vecs[i].ctl), bus.result_op, vecs[i].exp_r);
         check($sformatf("v%0d_ctl%0h_zero", i, vecs[i].ctl), {31'b0, bus.zero}, {31'b0, vecs[i].exp_z});
      end

      // Inputs changing between edges must not disturb the registered output.
      @(negedge clk);
      bus.ALU_control = 4'h0; bus.operando_A = 32'd100; bus.operando_B = 32'd23;
      @(posedge clk);
      #1;
      check("hold_before", bus.result_op, 32'd123);
      bus.ALU_control = 4'h1; bus.operando_A = 32'd5; bus.operando_B = 32'd5;
      #2;
      check("hold_midcycle_result", bus.result_op, 32'd123);
      check("hold_midcycle_zero", {31'b0, bus.zero}, 32'h0);
      @(posedge clk);
      #1;
      check("hold_next_edge_result", bus.result_op, 32'h0);
      check("hold_next_edge_zero", {31'b0, bus.zero}, 32'h1);

      // Asynchronous reset between edges, held across an edge, then released.
      bus.ALU_control = 4'h3; bus.operando_A = 32'h00F0; bus.operando_B = 32'h000F;
      @(posedge clk);
      #1;
      check("pre_reset_result", bus.result_op, 32'h00FF);
      #1 rst_n = 1'b0;
      #1;
      check("async_reset_result", bus.result_op, 32'h0);
      check("async_reset_zero", {31'b0, bus.zero}, 32'h1);
      bus.ALU_control = 4'h0; bus.operando_A = 32'd5; bus.operando_B = 32'd6;
      @(posedge clk);
      #1;
      check("reset_held_result", bus.result_op, 32'h0);
      check("reset_held_zero", {31'b0, bus.zero}, 32'h1);
      @(negedge clk) rst_n = 1'b1;
      #1;
      check("released_no_edge_result", bus.result_op, 32'h0);
      @(posedge clk);
      #1;
      check("first_after_release_result", bus.result_op, 32'd11);
      check("first_after_release_zero", {31'b0, bus.zero}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
